// File: rtl/izhikevich_step_ctrl_pkg.sv
// Shared types, neuron-model defaults and the 16-bit saturation helper
// for the Izhikevich time-step controller.
package izhikevich_step_ctrl_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned PROD_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        CALC,
        WRITE,
        DONE
    } state_t;

    localparam logic signed [DATA_W-1:0] DEF_V_PEAK  = 16'sd30;
    localparam logic signed [DATA_W-1:0] DEF_C_RESET = -16'sd65;
    localparam logic signed [DATA_W-1:0] DEF_D_INC   = 16'sd8;

    function automatic logic signed [DATA_W-1:0] sat16(input logic signed [PROD_W-1:0] x);
        if (x > 32'sd32767)
            return 16'sh7fff;
        if (x < -32'sd32768)
            return 16'sh8000;
        return x[DATA_W-1:0];
    endfunction

endpackage

// File: rtl/izhikevich_step_ctrl_state_bank.sv
// Per-neuron v/u register arrays: reset to the resting state, one write
// port, one read port for the active neuron and one for external readback.
module izh_state_bank
    import izhikevich_step_ctrl_pkg::*;
#(
    parameter int unsigned               N_NEURONS = 16,
    parameter int unsigned               IDX_W     = $clog2(N_NEURONS),
    parameter logic signed [DATA_W-1:0]  C_RESET   = DEF_C_RESET
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we,
    input  logic [IDX_W-1:0]         waddr,
    input  logic signed [DATA_W-1:0] wv,
    input  logic signed [DATA_W-1:0] wu,
    input  logic [IDX_W-1:0]         raddr_a,
    output logic signed [DATA_W-1:0] rv_a,
    output logic signed [DATA_W-1:0] ru_a,
    input  logic [IDX_W-1:0]         raddr_b,
    output logic signed [DATA_W-1:0] rv_b,
    output logic signed [DATA_W-1:0] ru_b
);

    localparam logic signed [DATA_W-1:0] U_RESET = C_RESET >>> 2;

    logic signed [DATA_W-1:0] v_mem [N_NEURONS];
    logic signed [DATA_W-1:0] u_mem [N_NEURONS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < N_NEURONS; i++) begin
                v_mem[i] <= C_RESET;
                u_mem[i] <= U_RESET;
            end
        end else if (we) begin
            v_mem[waddr] <= wv;
            u_mem[waddr] <= wu;
        end
    end

    assign rv_a = v_mem[raddr_a];
    assign ru_a = u_mem[raddr_a];
    assign rv_b = v_mem[raddr_b];
    assign ru_b = u_mem[raddr_b];

endmodule

// File: rtl/izhikevich_step_ctrl.sv
// Sequences one Izhikevich time step over all neurons through a shared
// external v_next datapath, applying threshold/reset and the u recovery update.
module izhikevich_step_ctrl
    import izhikevich_step_ctrl_pkg::*;
#(
    parameter int unsigned               N_NEURONS = 16,
    parameter int unsigned               IDX_W     = $clog2(N_NEURONS),
    parameter logic signed [DATA_W-1:0]  V_PEAK    = DEF_V_PEAK,
    parameter logic signed [DATA_W-1:0]  C_RESET   = DEF_C_RESET,
    parameter logic signed [DATA_W-1:0]  D_INC     = DEF_D_INC
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic signed [DATA_W-1:0] dt,
    output logic                     busy,
    output logic                     done,
    output logic [IDX_W-1:0]         cur_addr,
    input  logic signed [DATA_W-1:0] cur_data,
    output logic signed [DATA_W-1:0] dp_v,
    output logic signed [DATA_W-1:0] dp_u,
    output logic signed [DATA_W-1:0] dp_I,
    output logic signed [DATA_W-1:0] dp_dt,
    input  logic signed [PROD_W-1:0] dp_v_next,
    output logic                     spike_valid,
    output logic [IDX_W-1:0]         spike_id,
    input  logic [IDX_W-1:0]         rd_addr,
    output logic signed [DATA_W-1:0] rd_v,
    output logic signed [DATA_W-1:0] rd_u
);

    localparam int unsigned EXT_W = DATA_W + 1;
    localparam int unsigned SPK_W = DATA_W + 2;

    state_t                   state;
    logic [IDX_W-1:0]         idx;
    logic signed [DATA_W-1:0] dt_q;
    logic signed [DATA_W-1:0] dpv_q;
    logic signed [DATA_W-1:0] dpu_q;
    logic signed [DATA_W-1:0] dpdt_q;
    logic signed [PROD_W-1:0] vn_q;

    logic signed [DATA_W-1:0] bank_v;
    logic signed [DATA_W-1:0] bank_u;
    logic signed [DATA_W-1:0] v_sat;
    logic signed [EXT_W-1:0]  u_diff;
    logic signed [EXT_W-1:0]  u_new;
    logic signed [SPK_W-1:0]  u_spk;
    logic                     spike_c;
    logic                     we_c;
    logic signed [DATA_W-1:0] wv_c;
    logic signed [DATA_W-1:0] wu_c;

    izh_state_bank #(
        .N_NEURONS (N_NEURONS),
        .IDX_W     (IDX_W),
        .C_RESET   (C_RESET)
    ) u_bank (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (we_c),
        .waddr   (idx),
        .wv      (wv_c),
        .wu      (wu_c),
        .raddr_a (idx),
        .rv_a    (bank_v),
        .ru_a    (bank_u),
        .raddr_b (rd_addr),
        .rv_b    (rd_v),
        .ru_b    (rd_u)
    );

    // Write-back value: bank still holds the old v/u of idx during WRITE.
    always_comb begin
        v_sat   = sat16(vn_q);
        u_diff  = EXT_W'(bank_v >>> 2) - EXT_W'(bank_u);
        u_new   = EXT_W'(bank_u) + (u_diff >>> 6);
        u_spk   = SPK_W'(u_new) + SPK_W'(D_INC);
        spike_c = (v_sat >= V_PEAK);
        we_c    = (state == WRITE);
        wv_c    = spike_c ? C_RESET : v_sat;
        wu_c    = spike_c ? sat16(PROD_W'(u_spk)) : sat16(PROD_W'(u_new));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            idx         <= '0;
            dt_q        <= '0;
            dpv_q       <= '0;
            dpu_q       <= '0;
            dpdt_q      <= '0;
            vn_q        <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            spike_valid <= 1'b0;
            spike_id    <= '0;
        end else begin
            done        <= 1'b0;
            spike_valid <= 1'b0;
            dpv_q       <= '0;
            dpu_q       <= '0;
            dpdt_q      <= '0;
            case (state)
                IDLE: begin
                    if (start) begin
                        dt_q  <= dt;
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= FETCH;
                    end
                end
                FETCH: begin
                    // Operands are staged so they are stable for the whole CALC cycle.
                    dpv_q  <= bank_v;
                    dpu_q  <= bank_u;
                    dpdt_q <= dt_q;
                    state  <= CALC;
                end
                CALC: begin
                    vn_q  <= dp_v_next;
                    state <= WRITE;
                end
                WRITE: begin
                    spike_valid <= spike_c;
                    if (spike_c)
                        spike_id <= idx;
                    if (idx == IDX_W'(N_NEURONS - 1)) begin
                        state <= DONE;
                    end else begin
                        idx   <= idx + IDX_W'(1);
                        state <= FETCH;
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign cur_addr = idx;
    assign dp_v     = dpv_q;
    assign dp_u     = dpu_q;
    assign dp_dt    = dpdt_q;
    assign dp_I     = (state == CALC) ? cur_data : '0;

endmodule

// File: tb/tb_izhikevich_step_ctrl.sv
// Self-checking bench for izhikevich_step_ctrl with N_NEURONS=4: table-driven
// steps plus hand-written sequences for start masking, back-to-back and mid-step reset.
module tb_izhikevich_step_ctrl;

    localparam int unsigned N  = 4;
    localparam int unsigned IW = 2;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic signed [15:0] dt = '0;
    logic               busy;
    logic               done;
    logic [IW-1:0]      cur_addr;
    logic signed [15:0] cur_data = '0;
    logic signed [15:0] dp_v;
    logic signed [15:0] dp_u;
    logic signed [15:0] dp_I;
    logic signed [15:0] dp_dt;
    logic signed [31:0] dp_v_next;
    logic               spike_valid;
    logic [IW-1:0]      spike_id;
    logic [IW-1:0]      rd_addr = '0;
    logic signed [15:0] rd_v;
    logic signed [15:0] rd_u;

    logic signed [31:0] vnext_tab [N];
    logic signed [15:0] cur_mem [N];

    typedef struct {
        logic signed [31:0] vnext;
        bit                 spike;
        logic signed [15:0] v;
        logic signed [15:0] u;
    } vec_t;

    vec_t tab [2*N];

    int checks = 0;
    int errors = 0;
    int done_cycles = 0;
    int exp_q [$];

    izhikevich_step_ctrl #(
        .N_NEURONS (N),
        .IDX_W     (IW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dt          (dt),
        .busy        (busy),
        .done        (done),
        .cur_addr    (cur_addr),
        .cur_data    (cur_data),
        .dp_v        (dp_v),
        .dp_u        (dp_u),
        .dp_I        (dp_I),
        .dp_dt       (dp_dt),
        .dp_v_next   (dp_v_next),
        .spike_valid (spike_valid),
        .spike_id    (spike_id),
        .rd_addr     (rd_addr),
        .rd_v        (rd_v),
        .rd_u        (rd_u)
    );

    always #5 clk = ~clk;

    // Current memory with one-cycle read latency; datapath stub keyed by neuron.
    always @(posedge clk) cur_data <= cur_mem[cur_addr];
    assign dp_v_next = vnext_tab[cur_addr];

    task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done === 1'b1)
            done_cycles++;
        if (spike_valid === 1'b1) begin
            if (exp_q.size() == 0)
                chk("spike_unexpected", 32'(spike_id), -1);
            else
                chk("spike_id", 32'(spike_id), exp_q.pop_front());
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic check_bank(input logic signed [15:0] ev, input logic signed [15:0] eu);
        for (int n = 0; n < int'(N); n++) begin
            rd_addr = IW'(n);
            #1;
            chk("rd_v", rd_v, ev);
            chk("rd_u", rd_u, eu);
        end
    endtask

    // Caller sits at a negedge; start is accepted at the next posedge.
    task automatic run_step(input logic signed [15:0] d, input bit noise, input bit fresh);
        int cyc;
        start = 1'b1;
        dt    = d;
        @(negedge clk);
        start = 1'b0;
        cyc   = 0;
        chk("busy_after_start", busy, 1);
        chk("done_low_after_start", done, 0);
        while (done !== 1'b1 && cyc < 100) begin
            start = noise && cyc < 3;
            if (noise && cyc < 3)
                dt = 16'sd7;
            if (cyc % 3 == 1) begin
                chk("cur_addr_calc", 32'(cur_addr), cyc / 3);
                chk("dp_dt", dp_dt, d);
                chk("dp_I", dp_I, cur_mem[cur_addr]);
                if (fresh) begin
                    chk("dp_v", dp_v, -65);
                    chk("dp_u", dp_u, -17);
                end
            end else if (cyc < 12) begin
                chk("cur_addr_seq", 32'(cur_addr), cyc / 3);
                chk("dp_dt_idle", dp_dt, 0);
                chk("dp_I_idle", dp_I, 0);
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        chk("done_latency", cyc, 13);
        chk("busy_at_done", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc;
        for (int n = 0; n < int'(N); n++) begin
            cur_mem[n]   = 16'(100 + 3 * n);
            vnext_tab[n] = 32'sd0;
        end
        for (int n = 0; n < int'(N); n++)
            tab[n] = '{32'sd90, 1'b1, -16'sd65, -16'sd9};
        tab[4] = '{32'sd40000,  1'b1, -16'sd65,    -16'sd9};
        tab[5] = '{-32'sd70000, 1'b0, -16'sd32768, -16'sd17};
        tab[6] = '{32'sd29,     1'b0, 16'sd29,     -16'sd17};
        tab[7] = '{32'sd30,     1'b1, -16'sd65,    -16'sd9};

        // Reset state
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_spike_valid", spike_valid, 0);
        chk("rst_spike_id", 32'(spike_id), 0);
        chk("rst_cur_addr", 32'(cur_addr), 0);
        chk("rst_dp_v", dp_v, 0);
        chk("rst_dp_u", dp_u, 0);
        chk("rst_dp_dt", dp_dt, 0);
        chk("rst_dp_I", dp_I, 0);
        check_bank(-16'sd65, -16'sd17);
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven steps, each from reset
        for (int g = 0; g < 2; g++) begin
            do_reset();
            for (int n = 0; n < int'(N); n++) begin
                vnext_tab[n] = tab[g*N + n].vnext;
                if (tab[g*N + n].spike)
                    exp_q.push_back(n);
            end
            run_step(16'sd1, 1'b0, 1'b1);
            for (int n = 0; n < int'(N); n++) begin
                rd_addr = IW'(n);
                #1;
                chk("tab_v", rd_v, tab[g*N + n].v);
                chk("tab_u", rd_u, tab[g*N + n].u);
            end
            chk("tab_spikes_drained", exp_q.size(), 0);
        end

        // Start pulses while busy are ignored; dt stays latched
        do_reset();
        for (int n = 0; n < int'(N); n++)
            vnext_tab[n] = 32'sd10;
        dc = done_cycles;
        run_step(16'sd5, 1'b1, 1'b1);
        @(negedge clk);
        #1;
        chk("single_done", done_cycles - dc, 1);
        chk("idle_busy", busy, 0);
        check_bank(16'sd10, -16'sd17);

        // Back-to-back steps, second start in the done cycle
        for (int n = 0; n < int'(N); n++)
            vnext_tab[n] = 32'sd90;
        for (int k = 0; k < 2; k++)
            for (int n = 0; n < int'(N); n++)
                exp_q.push_back(n);
        @(negedge clk);
        dc = done_cycles;
        run_step(16'sd1, 1'b0, 1'b0);
        run_step(16'sd2, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        chk("b2b_done_count", done_cycles - dc, 2);
        chk("b2b_spikes_drained", exp_q.size(), 0);
        check_bank(-16'sd65, -16'sd2);

        // Reset during WRITE of neuron 2 abandons the step
        do_reset();
        for (int n = 0; n < int'(N); n++)
            vnext_tab[n] = 32'sd10;
        start = 1'b1;
        dt    = 16'sd1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        chk("mid_busy_before_rst", busy, 1);
        chk("mid_cur_addr", 32'(cur_addr), 2);
        dc = done_cycles;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_cur_addr", 32'(cur_addr), 0);
        repeat (3) @(negedge clk);
        #1;
        chk("mid_rst_no_done", done_cycles - dc, 0);
        check_bank(-16'sd65, -16'sd17);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("post_rst_no_done", done_cycles - dc, 0);
        chk("final_spikes_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/izhikevich_step_ctrl.md
IZHIKEVICH_STEP_CTRL -- requirements
Module: izhikevich_step_ctrl

Interface
REQ-001 Parameter: N_NEURONS, 16, number of neurons time-multiplexed onto the single shared v_next datapath (2..256).
REQ-002 Parameter: IDX_W, $clog2(N_NEURONS), neuron index width.
REQ-003 Parameter: V_PEAK, 30, spike threshold (signed 16-bit).
REQ-004 Parameter: C_RESET, -65, post-spike v value and v reset value.
REQ-005 Parameter: D_INC, 8, post-spike u increment.
REQ-006 Port: clk  input  1  single clock, rising edge.
REQ-007 Port: rst_n  input  1  asynchronous active-low reset.
REQ-008 Port: start  input  1  one-cycle request to run one time step over all neurons.
REQ-009 Port: dt  input  16 signed  time step, sampled on accepted start.
REQ-010 Port: busy  output  1  high from accepted start until done.
REQ-011 Port: done  output  1  one-cycle pulse when the step completes.
REQ-012 Port: cur_addr  output  IDX_W  neuron index for the input-current memory.
REQ-013 Port: cur_data  input  16 signed  input current I, valid one cycle after cur_addr.
REQ-014 Ports: dp_v, dp_u, dp_I, dp_dt  output  16 signed each  operands to the shared combinational v_next datapath.
REQ-015 Port: dp_v_next  input  32 signed  datapath result, combinational from dp_* operands.
REQ-016 Ports: spike_valid  output  1, spike_id  output  IDX_W  one-cycle spike event and its neuron index.
REQ-017 Ports: rd_addr  input  IDX_W; rd_v, rd_u  output  16 signed  combinational state readback.

Function
REQ-018 FSM states: IDLE, FETCH, CALC, WRITE, DONE; reset state IDLE.
REQ-019 IDLE: start=1 latches dt, sets idx=0, goes to FETCH; start is ignored in every other state.
REQ-020 FETCH: drive cur_addr=idx; go to CALC.
REQ-021 CALC: drive dp_v=v[idx], dp_u=u[idx], dp_I=cur_data, dp_dt=latched dt; register dp_v_next and I; go to WRITE.
REQ-022 WRITE: saturate registered dp_v_next to [-32768, 32767] giving v_sat; u_new = u + (((v>>>2) - u)>>>6), using old v and u, arithmetic shifts.
REQ-023 WRITE, v_sat >= V_PEAK: v[idx]<=C_RESET, u[idx]<=sat16(u_new+D_INC), spike_valid=1, spike_id=idx for exactly that cycle.
REQ-024 WRITE, v_sat < V_PEAK: v[idx]<=v_sat, u[idx]<=u_new, spike_valid=0.
REQ-025 WRITE: if idx==N_NEURONS-1 go to DONE, else idx<=idx+1 and go to FETCH; idx never wraps past N_NEURONS-1.
REQ-026 DONE: done=1 for one cycle, busy deasserts in the same cycle, return to IDLE.
REQ-027 Latency: done asserts 3*N_NEURONS+1 cycles after the accepting start edge.
REQ-028 busy=1 in FETCH, CALC and WRITE; busy=0 in IDLE and DONE.
REQ-029 dp_* outputs are 0 outside CALC; cur_addr holds idx in all states.
REQ-030 Readback: rd_v/rd_u reflect the current register contents; a write in WRITE is visible the next cycle.
REQ-031 All sums use at least 17-bit intermediates before saturation; no silent wrap.

Reset
REQ-032 rst_n low asynchronously forces IDLE, idx=0, busy=0, done=0, spike_valid=0, spike_id=0, latched dt=0.
REQ-033 rst_n low sets every v[i]=C_RESET and every u[i]=C_RESET>>>2 (-17 at the default value).
REQ-034 Reset mid-step abandons the step with no done pulse; state is reinitialised per REQ-033.

Structure
REQ-035 The shared package holds the FSM state enum, the V_PEAK/C_RESET/D_INC defaults, and the sat16 saturation function.
REQ-036 One sub-module, izh_state_bank, holds the v/u register arrays with reset init, one write port and two read ports (idx and rd_addr).
REQ-037 The v_next datapath remains external to this block.

Verification
REQ-038 N=4, reset, start with dt=1, bench datapath returns 90 for every neuron: 4 spike pulses with ids 0..3; afterwards every v=-65 and every u=-9; done at cycle 13.
REQ-039 dp_v_next=40000 -> v_sat=32767 -> spike, v=-65; dp_v_next=-70000 -> v=-32768, no spike.
REQ-040 dp_v_next=29 -> no spike, v=29; dp_v_next=30 -> spike (threshold boundary).
REQ-041 start pulsed during FETCH/CALC/WRITE -> ignored; exactly one done pulse; latched dt unchanged.
REQ-042 rst_n low during WRITE of neuron 2 -> immediate IDLE, no done pulse, rd_v=-65 and rd_u=-17 for all neurons.
REQ-043 Two back-to-back steps (start in the cycle after done) -> second done arrives 13 cycles after its start (N=4); cur_addr sequence is 0..3 in each step.
